// File: rtl/mips_mem_pkg.sv
// Shared encodings and types for the MIPS memory-access stage.
package mips_mem_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  typedef enum logic {IDLE, BUSY} mem_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] wreg;
    logic        regwrite;
    logic        memtoreg;
  } mem_wb_t;

  function automatic logic is_unsigned_load(input logic [5:0] op);
    return (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: lane enables, store replication, misalign check and
// little-endian load extraction with sign/zero extension.
module mem_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  byte_en_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [31:0] rdata_o
);

  logic [15:0] half_w;
  logic [7:0]  byte_w;

  assign half_w = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign byte_w = rdata_i[{addr_i, 3'b000} +: 8];

  always_comb begin
    byte_en_o  = 4'b0000;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    rdata_o    = rdata_i;
    unique case (size_i)
      SZ_WORD: begin
        byte_en_o  = 4'b1111;
        misalign_o = (addr_i != 2'b00);
      end
      SZ_HALF: begin
        byte_en_o  = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_i[0];
        rdata_o    = unsigned_i ? {16'h0000, half_w} : {{16{half_w[15]}}, half_w};
      end
      SZ_BYTE: begin
        byte_en_o = 4'b0001 << addr_i;
        wdata_o   = {4{wdata_i[7:0]}};
        rdata_o   = unsigned_i ? {24'h000000, byte_w} : {{24{byte_w[7]}}, byte_w};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: request/ack data-memory FSM with bus timeout, alignment and the
// MEM/WB pipeline register. DMemAck -> MemStall is a combinational path.
//
//   state | meaning
//   IDLE  | accept op from EX/MEM; non-memory ops pass straight to MEM/WB
//   BUSY  | request held from latched values until ack or timeout
module mem_stage
  import mips_mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Flush,
  input  logic [31:0] InstructionIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] ReadData2In,
  input  logic [31:0] WriteRegisterIn,
  input  logic [1:0]  MemReadIn,
  input  logic [1:0]  MemWriteIn,
  input  logic        RegWriteIn,
  input  logic        MemToRegIn,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemByteEn,
  input  logic [31:0] DMemRData,
  input  logic        DMemAck,
  output logic        MemStall,
  output logic        AddrError,
  output logic        BusError,
  output logic [31:0] InstructionOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] ReadDataOut,
  output logic [31:0] WriteRegisterOut,
  output logic        RegWriteOut,
  output logic        MemToRegOut
);

  localparam logic [7:0] TO_LAST = 8'(BUS_TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  mem_wb_t     wb_q, wb_d, ctl_q, ctl_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d, lo_q, lo_d;

  logic        busy, mem_op, timeout, stall, addr_err, bus_err;
  logic [1:0]  size_in, al_size, al_addr;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;
  logic        al_misalign;

  assign busy    = (state_q == BUSY);
  assign mem_op  = (MemReadIn != SZ_NONE) || (MemWriteIn != SZ_NONE);
  assign size_in = (MemReadIn != SZ_NONE) ? MemReadIn : MemWriteIn;
  assign al_size = busy ? size_q : size_in;
  assign al_addr = busy ? lo_q : ALUResultIn[1:0];
  assign timeout = busy && !DMemAck && (cnt_q == TO_LAST);

  mem_align u_align (
    .size_i     (al_size),
    .addr_i     (al_addr),
    .unsigned_i (is_unsigned_load(ctl_q.instr[31:26])),
    .wdata_i    (ReadData2In),
    .rdata_i    (DMemRData),
    .byte_en_o  (al_be),
    .wdata_o    (al_wdata),
    .misalign_o (al_misalign),
    .rdata_o    (al_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    wb_d     = wb_q;
    ctl_d    = ctl_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    size_d   = size_q;
    lo_d     = lo_q;
    stall    = 1'b0;
    addr_err = 1'b0;
    bus_err  = 1'b0;
    // Outputs stay quiet while reset is held, even with a live op upstream.
    if (Reset_n) begin
      unique case (state_q)
        IDLE: begin
          if (Flush) begin
            wb_d = '0;
          end else if (!mem_op) begin
            wb_d.instr    = InstructionIn;
            wb_d.alu      = ALUResultIn;
            wb_d.rdata    = '0;
            wb_d.wreg     = WriteRegisterIn;
            wb_d.regwrite = RegWriteIn;
            wb_d.memtoreg = MemToRegIn;
          end else if (al_misalign) begin
            addr_err = 1'b1;
            wb_d     = '0;
          end else begin
            stall          = 1'b1;
            wb_d           = '0;
            ctl_d.instr    = InstructionIn;
            ctl_d.alu      = ALUResultIn;
            ctl_d.rdata    = '0;
            ctl_d.wreg     = WriteRegisterIn;
            ctl_d.regwrite = RegWriteIn;
            ctl_d.memtoreg = MemToRegIn;
            addr_d         = {ALUResultIn[31:2], 2'b00};
            wdata_d        = al_wdata;
            be_d           = al_be;
            we_d           = (MemReadIn == SZ_NONE);
            size_d         = size_in;
            lo_d           = ALUResultIn[1:0];
            state_d        = BUSY;
          end
        end
        BUSY: begin
          cnt_d = cnt_q + 8'd1;
          wb_d  = '0;
          if (DMemAck) begin
            wb_d = ctl_q;
            if (we_q) wb_d.regwrite = 1'b0;
            else      wb_d.rdata    = al_rdata;
            state_d = IDLE;
          end else if (timeout) begin
            bus_err = 1'b1;
            state_d = IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
      ctl_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_NONE;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      ctl_q   <= ctl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      size_q  <= size_d;
      lo_q    <= lo_d;
    end
  end

  assign DMemReq    = busy;
  assign DMemWe     = busy && we_q;
  assign DMemAddr   = busy ? addr_q : '0;
  assign DMemWData  = busy ? wdata_q : '0;
  assign DMemByteEn = busy ? be_q : '0;
  assign MemStall   = stall;
  assign AddrError  = addr_err;
  assign BusError   = bus_err;

  assign InstructionOut   = wb_q.instr;
  assign ALUResultOut     = wb_q.alu;
  assign ReadDataOut      = wb_q.rdata;
  assign WriteRegisterOut = wb_q.wreg;
  assign RegWriteOut      = wb_q.regwrite;
  assign MemToRegOut      = wb_q.memtoreg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors for pass-through,
// aligned loads/stores, misalign, wait states, timeout, flush and reset.
module tb_mem_stage;

  logic        Clock = 1'b0, Reset_n = 1'b0, Flush = 1'b0;
  logic [31:0] InstructionIn = '0, ALUResultIn = '0, ReadData2In = '0, WriteRegisterIn = '0;
  logic [1:0]  MemReadIn = '0, MemWriteIn = '0;
  logic        RegWriteIn = 1'b0, MemToRegIn = 1'b0;
  logic        DMemReq, DMemWe, MemStall, AddrError, BusError, RegWriteOut, MemToRegOut;
  logic [31:0] DMemAddr, DMemWData, InstructionOut, ALUResultOut, ReadDataOut, WriteRegisterOut;
  logic [3:0]  DMemByteEn;
  logic [31:0] DMemRData = '0;
  logic        DMemAck = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage #(.BUS_TIMEOUT(4)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush),
    .InstructionIn(InstructionIn), .ALUResultIn(ALUResultIn), .ReadData2In(ReadData2In),
    .WriteRegisterIn(WriteRegisterIn), .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn),
    .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn),
    .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
    .DMemByteEn(DMemByteEn), .DMemRData(DMemRData), .DMemAck(DMemAck),
    .MemStall(MemStall), .AddrError(AddrError), .BusError(BusError),
    .InstructionOut(InstructionOut), .ALUResultOut(ALUResultOut), .ReadDataOut(ReadDataOut),
    .WriteRegisterOut(WriteRegisterOut), .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_op(input logic [5:0] opc, input logic [1:0] rd, input logic [1:0] wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic rw, input logic m2r, input logic [31:0] wreg);
    InstructionIn   = {opc, 26'h0};
    MemReadIn       = rd;
    MemWriteIn      = wr;
    ALUResultIn     = addr;
    ReadData2In     = wdata;
    RegWriteIn      = rw;
    MemToRegIn      = m2r;
    WriteRegisterIn = wreg;
  endtask

  task automatic idle_in();
    set_op(6'h00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    Flush = 1'b0;
  endtask

  // Entered at posedge+1 with an aligned memory op on the inputs; ends at
  // posedge+1 just after the acknowledged edge with inputs returned to idle.
  task automatic run_mem(input string tag, input int waits, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic exp_we);
    int stalls = 0;
    int writes = 0;
    #1;
    check({tag, "/idle_req"}, 32'(DMemReq), 0);
    if (MemStall) stalls++;
    for (int c = 0; c <= waits; c++) begin
      tick();
      if (c == waits) begin
        DMemRData = rdata;
        DMemAck   = 1'b1;
      end
      #1;
      check({tag, "/req"}, 32'(DMemReq), 1);
      check({tag, "/addr"}, DMemAddr, exp_addr);
      check({tag, "/be"}, 32'(DMemByteEn), 32'(exp_be));
      check({tag, "/wdata"}, DMemWData, exp_wdata);
      check({tag, "/we"}, 32'(DMemWe), 32'(exp_we));
      if (MemStall) stalls++;
      if (RegWriteOut || ALUResultOut != 0 || InstructionOut != 0) writes++;
    end
    tick();
    DMemAck = 1'b0;
    idle_in();
    check({tag, "/stall_cycles"}, 32'(stalls), 32'(waits + 1));
    check({tag, "/bubble_while_busy"}, 32'(writes), 0);
  endtask

  initial begin
    #3;
    check("rst/req", 32'(DMemReq), 0);
    check("rst/stall", 32'(MemStall), 0);
    check("rst/alu", ALUResultOut, 0);
    check("rst/regwrite", 32'(RegWriteOut), 0);
    tick();
    Reset_n = 1'b1;
    tick();

    // Non-memory pass-through, one-cycle latency
    set_op(6'h00, 2'b00, 2'b00, 32'h1234, 32'h0, 1'b1, 1'b0, 32'd5);
    #1;
    check("nomem/req", 32'(DMemReq), 0);
    check("nomem/stall", 32'(MemStall), 0);
    tick();
    check("nomem/alu", ALUResultOut, 32'h1234);
    check("nomem/regwrite", 32'(RegWriteOut), 1);
    check("nomem/wreg", WriteRegisterOut, 5);
    check("nomem/rdata", ReadDataOut, 0);

    // Store word; RegWriteIn high on purpose to confirm it is dropped
    set_op(6'h2B, 2'b00, 2'b01, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'd3);
    run_mem("sw", 0, 32'h0, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b1);
    check("sw/alu", ALUResultOut, 32'h100);
    check("sw/regwrite", 32'(RegWriteOut), 0);
    check("sw/instr", InstructionOut, 32'hAC000000);

    // Word load
    set_op(6'h23, 2'b01, 2'b00, 32'h100, 32'h0, 1'b1, 1'b1, 32'd8);
    run_mem("lw", 0, 32'hDEADBEEF, 32'h100, 4'b1111, 32'h0, 1'b0);
    check("lw/rdata", ReadDataOut, 32'hDEADBEEF);
    check("lw/regwrite", 32'(RegWriteOut), 1);
    check("lw/memtoreg", 32'(MemToRegOut), 1);
    check("lw/wreg", WriteRegisterOut, 8);

    // Byte/half loads with sign and zero extension
    set_op(6'h20, 2'b11, 2'b00, 32'h103, 32'h0, 1'b1, 1'b1, 32'd9);
    run_mem("lb", 0, 32'h80123456, 32'h100, 4'b1000, 32'h0, 1'b0);
    check("lb/rdata", ReadDataOut, 32'hFFFFFF80);
    set_op(6'h24, 2'b11, 2'b00, 32'h103, 32'h0, 1'b1, 1'b1, 32'd9);
    run_mem("lbu", 0, 32'h80123456, 32'h100, 4'b1000, 32'h0, 1'b0);
    check("lbu/rdata", ReadDataOut, 32'h00000080);
    set_op(6'h21, 2'b10, 2'b00, 32'h102, 32'h0, 1'b1, 1'b1, 32'd9);
    run_mem("lh_hi", 0, 32'h80017F00, 32'h100, 4'b1100, 32'h0, 1'b0);
    check("lh_hi/rdata", ReadDataOut, 32'hFFFF8001);
    set_op(6'h25, 2'b10, 2'b00, 32'h102, 32'h0, 1'b1, 1'b1, 32'd9);
    run_mem("lhu", 0, 32'h80017F00, 32'h100, 4'b1100, 32'h0, 1'b0);
    check("lhu/rdata", ReadDataOut, 32'h00008001);
    set_op(6'h21, 2'b10, 2'b00, 32'h100, 32'h0, 1'b1, 1'b1, 32'd9);
    run_mem("lh_lo", 0, 32'h80017F00, 32'h100, 4'b0011, 32'h0, 1'b0);
    check("lh_lo/rdata", ReadDataOut, 32'h00007F00);

    // Byte/half stores replicate data across lanes
    set_op(6'h28, 2'b00, 2'b11, 32'h101, 32'h000000AB, 1'b0, 1'b0, 32'd0);
    run_mem("sb", 0, 32'h0, 32'h100, 4'b0010, 32'hABABABAB, 1'b1);
    set_op(6'h29, 2'b00, 2'b10, 32'h102, 32'h00001234, 1'b0, 1'b0, 32'd0);
    run_mem("sh", 0, 32'h0, 32'h100, 4'b1100, 32'h12341234, 1'b1);

    // Both read and write set: read wins
    set_op(6'h23, 2'b01, 2'b01, 32'h204, 32'h11111111, 1'b1, 1'b1, 32'd4);
    run_mem("rdwins", 0, 32'h5A5A5A5A, 32'h204, 4'b1111, 32'h11111111, 1'b0);
    check("rdwins/rdata", ReadDataOut, 32'h5A5A5A5A);

    // Misaligned half and word
    set_op(6'h21, 2'b10, 2'b00, 32'h1001, 32'h0, 1'b1, 1'b1, 32'd7);
    #1;
    check("mis_h/adderr", 32'(AddrError), 1);
    check("mis_h/stall", 32'(MemStall), 0);
    tick();
    check("mis_h/req", 32'(DMemReq), 0);
    check("mis_h/regwrite", 32'(RegWriteOut), 0);
    check("mis_h/wreg", WriteRegisterOut, 0);
    set_op(6'h23, 2'b01, 2'b00, 32'h102, 32'h0, 1'b1, 1'b1, 32'd7);
    #1;
    check("mis_w/adderr", 32'(AddrError), 1);
    tick();
    idle_in();
    #1;
    check("mis_w/req", 32'(DMemReq), 0);
    check("mis_w/adderr_pulse", 32'(AddrError), 0);

    // Three wait cycles: four stall cycles, one write-back
    set_op(6'h23, 2'b01, 2'b00, 32'h200, 32'h0, 1'b1, 1'b1, 32'd12);
    run_mem("wait3", 3, 32'hCAFEF00D, 32'h200, 4'b1111, 32'h0, 1'b0);
    check("wait3/rdata", ReadDataOut, 32'hCAFEF00D);
    check("wait3/regwrite", 32'(RegWriteOut), 1);
    tick();
    check("wait3/single_commit", 32'(RegWriteOut), 0);

    // Timeout after 4 BUSY cycles with no ack
    set_op(6'h23, 2'b01, 2'b00, 32'h300, 32'h0, 1'b1, 1'b1, 32'd2);
    #1;
    check("to/idle_stall", 32'(MemStall), 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      #1;
      check("to/buserr", 32'(BusError), (c == 4) ? 1 : 0);
      check("to/stall", 32'(MemStall), (c == 4) ? 0 : 1);
    end
    tick();
    idle_in();
    #1;
    check("to/req_after", 32'(DMemReq), 0);
    check("to/regwrite", 32'(RegWriteOut), 0);
    check("to/buserr_pulse", 32'(BusError), 0);

    // Flush in IDLE makes a bubble, even for a memory op
    set_op(6'h23, 2'b01, 2'b00, 32'h100, 32'h0, 1'b1, 1'b1, 32'd6);
    Flush = 1'b1;
    #1;
    check("flush/stall", 32'(MemStall), 0);
    tick();
    check("flush/req", 32'(DMemReq), 0);
    check("flush/regwrite", 32'(RegWriteOut), 0);
    idle_in();

    // Flush during BUSY is ignored
    set_op(6'h23, 2'b01, 2'b00, 32'h100, 32'h0, 1'b1, 1'b1, 32'd6);
    tick();
    Flush = 1'b1;
    DMemRData = 32'h13572468;
    DMemAck = 1'b1;
    tick();
    DMemAck = 1'b0;
    idle_in();
    check("flush_busy/rdata", ReadDataOut, 32'h13572468);
    check("flush_busy/regwrite", 32'(RegWriteOut), 1);

    // Ack outside BUSY is ignored
    set_op(6'h00, 2'b00, 2'b00, 32'h77, 32'h0, 1'b1, 1'b0, 32'd1);
    DMemRData = 32'hFFFFFFFF;
    DMemAck = 1'b1;
    tick();
    DMemAck = 1'b0;
    check("stray_ack/alu", ALUResultOut, 32'h77);
    check("stray_ack/rdata", ReadDataOut, 0);

    // Reset with a populated MEM/WB and a pending op in IDLE
    set_op(6'h23, 2'b01, 2'b00, 32'h400, 32'h0, 1'b1, 1'b1, 32'd3);
    #1;
    check("rst_idle/stall_pre", 32'(MemStall), 1);
    Reset_n = 1'b0;
    #1;
    check("rst_idle/stall", 32'(MemStall), 0);
    check("rst_idle/alu", ALUResultOut, 0);
    check("rst_idle/regwrite", 32'(RegWriteOut), 0);
    tick();
    Reset_n = 1'b1;

    // Reset mid-BUSY
    tick();
    #1;
    check("rst_busy/req_pre", 32'(DMemReq), 1);
    Reset_n = 1'b0;
    #1;
    check("rst_busy/req", 32'(DMemReq), 0);
    check("rst_busy/addr", DMemAddr, 0);
    check("rst_busy/stall", 32'(MemStall), 0);
    idle_in();
    tick();
    Reset_n = 1'b1;

    // Back in IDLE after reset: pass-through works
    set_op(6'h00, 2'b00, 2'b00, 32'h99, 32'h0, 1'b1, 1'b0, 32'd2);
    tick();
    check("post_rst/alu", ALUResultOut, 32'h99);
    idle_in();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
